// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard / MDU scheduling logic.
package pipe_pkg;

  localparam logic [1:0] TUSE_NONE      = 2'd3;
  localparam int         MULT_CYCLES_DEF = 5;
  localparam int         DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Busy down-counter width: wide enough for the longer op, never below 4 bits.
  function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
    int longest;
    int width;
    longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    width   = $clog2(longest + 1);
    return (width < 4) ? 4 : width;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// D/E/M-stage hazard inputs and stall/flush outputs of pipe_stall_ctrl.
// master = pipeline datapath side, slave = the stall controller.
interface pipe_stall_ctrl_if;

  logic [4:0]  a1_d;
  logic [4:0]  a2_d;
  logic [1:0]  tuse_rs_d;
  logic [1:0]  tuse_rt_d;
  logic [4:0]  a3_e;
  logic [4:0]  a3_m;
  logic [1:0]  tnew_e;
  logic [1:0]  tnew_m;
  logic        regwrite_e;
  logic        regwrite_m;
  logic        md_use_d;
  logic        md_start_e;
  logic        md_div_e;
  logic        stall;
  logic        flush_e;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output a1_d, a2_d, tuse_rs_d, tuse_rt_d, a3_e, a3_m, tnew_e, tnew_m,
           regwrite_e, regwrite_m, md_use_d, md_start_e, md_div_e,
    input  stall, flush_e, md_busy, stall_cnt
  );

  modport slave (
    input  a1_d, a2_d, tuse_rs_d, tuse_rt_d, a3_e, a3_m, tnew_e, tnew_m,
           regwrite_e, regwrite_m, md_use_d, md_start_e, md_div_e,
    output stall, flush_e, md_busy, stall_cnt
  );

endinterface

// File: rtl/pipe_stall_ctrl_mdu_sched.sv
// mdu_sched: busy-window FSM for the multi-cycle HI/LO unit.
// md_busy covers the issue cycle plus N following cycles.
module mdu_sched
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_e,
  input  logic md_div_e,
  output logic md_busy
);

  localparam int CW = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e      r_state;
  mdu_state_e      w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [CW-1:0]   w_load_cnt;

  assign w_load_cnt = md_div_e ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      MDU_IDLE: begin
        if (md_start_e) begin
          w_state_next = MDU_BUSY;
          w_cnt_next   = w_load_cnt;
        end
      end
      MDU_BUSY: begin
        // A fresh issue while busy restarts the window for the new op.
        if (md_start_e) begin
          w_cnt_next = w_load_cnt;
        end else if (r_cnt == CW'(1)) begin
          w_state_next = MDU_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_next = MDU_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign md_busy = reset & (md_start_e | (r_state == MDU_BUSY));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Tuse/Tnew hazard detector and HI/LO busy stall for the 5-stage pipeline.
// Optional STALL_CNT_EN build adds a saturating stall-cycle counter.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stall_ctrl_if.slave  bus
);

  logic [4:0] w_src_a    [2];
  logic [1:0] w_src_tuse [2];
  logic [1:0] w_hit;
  logic       w_md_busy;
  logic       w_stall;

  assign w_src_a[0]    = bus.a1_d;
  assign w_src_a[1]    = bus.a2_d;
  assign w_src_tuse[0] = bus.tuse_rs_d;
  assign w_src_tuse[1] = bus.tuse_rt_d;

  // A producer hazards only if its result arrives later than the consumer needs it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic w_e_hit;
    logic w_m_hit;
    assign w_e_hit = bus.regwrite_e && (bus.a3_e == w_src_a[gi]) &&
                     (bus.tnew_e > w_src_tuse[gi]);
    assign w_m_hit = bus.regwrite_m && (bus.a3_m == w_src_a[gi]) &&
                     (bus.tnew_m > w_src_tuse[gi]);
    assign w_hit[gi] = (w_src_a[gi] != 5'd0) && (w_src_tuse[gi] != TUSE_NONE) &&
                       (w_e_hit || w_m_hit);
  end

  mdu_sched #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_sched (
    .clk        (clk),
    .reset      (reset),
    .md_start_e (bus.md_start_e),
    .md_div_e   (bus.md_div_e),
    .md_busy    (w_md_busy)
  );

  assign w_stall     = reset & ((|w_hit) | (bus.md_use_d & w_md_busy));
  assign bus.stall   = w_stall;
  assign bus.flush_e = w_stall;
  assign bus.md_busy = w_md_busy;

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl: directed vector table, MDU window sequences,
// reset abort, stall counter and a randomized run against a cycle-index model.
module tb_pipe_stall_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  typedef struct {
    logic [4:0] a1, a2;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] a3_e, a3_m;
    logic [1:0] tnew_e, tnew_m;
    logic       rw_e, rw_m;
    logic       exp_stall;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.a1_d = 5'd0;  bus.a2_d = 5'd0;
    bus.tuse_rs_d = 2'd3; bus.tuse_rt_d = 2'd3;
    bus.a3_e = 5'd0;  bus.a3_m = 5'd0;
    bus.tnew_e = 2'd0; bus.tnew_m = 2'd0;
    bus.regwrite_e = 1'b0; bus.regwrite_m = 1'b0;
    bus.md_use_d = 1'b0; bus.md_start_e = 1'b0; bus.md_div_e = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.a1_d = v.a1; bus.a2_d = v.a2;
    bus.tuse_rs_d = v.tuse_rs; bus.tuse_rt_d = v.tuse_rt;
    bus.a3_e = v.a3_e; bus.a3_m = v.a3_m;
    bus.tnew_e = v.tnew_e; bus.tnew_m = v.tnew_m;
    bus.regwrite_e = v.rw_e; bus.regwrite_m = v.rw_m;
  endtask

  // Hazard rule evaluated directly from the Tuse/Tnew definition.
  function automatic bit model_src_hit(int a, int tuse, int a3e, int tnewe, bit rwe,
                                       int a3m, int tnewm, bit rwm);
    if (a == 0 || tuse == 3) return 1'b0;
    return (rwe && a3e == a && tnewe > tuse) || (rwm && a3m == a && tnewm > tuse);
  endfunction

  // Pulse reset in the middle of a cycle, away from clock edges.
  task automatic pulse_reset();
    @(negedge clk); #1 reset = 1'b0;
    @(negedge clk); #1 reset = 1'b1;
  endtask

  task automatic mdu_seq(input bit div, input int n, input string tag);
    @(posedge clk); #1;
    set_idle();
    bus.md_start_e = 1'b1; bus.md_div_e = div; bus.md_use_d = 1'b1;
    @(negedge clk);
    check({tag, " issue stall"}, 32'(bus.stall), 32'd1);
    check({tag, " issue busy"},  32'(bus.md_busy), 32'd1);
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge clk); #1;
      bus.md_start_e = 1'b0;
      @(negedge clk);
      check($sformatf("%s stall t+%0d", tag, k), 32'(bus.stall), (k <= n) ? 32'd1 : 32'd0);
      check($sformatf("%s flush t+%0d", tag, k), 32'(bus.flush_e), (k <= n) ? 32'd1 : 32'd0);
    end
    $display("seq %s: window of %0d cycles after issue checked", tag, n);
  endtask

  initial begin
    int  cyc;
    int  busy_until;
    longint cnt_model;
    bit  exp_stall, exp_busy, hz;
    logic [31:0] exp_cnt;

    checks = 0;
    errors = 0;

    tbl[0] = '{5'd1, 5'd0, 2'd1, 2'd3, 5'd1, 5'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{5'd1, 5'd0, 2'd2, 2'd3, 5'd1, 5'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 5'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{5'd0, 5'd7, 2'd3, 2'd3, 5'd7, 5'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{5'd0, 5'd5, 2'd3, 2'd0, 5'd0, 5'd5, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{5'd0, 5'd5, 2'd3, 2'd0, 5'd0, 5'd5, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{5'd3, 5'd0, 2'd0, 2'd3, 5'd3, 5'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{5'd9, 5'd0, 2'd2, 2'd3, 5'd9, 5'd0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{5'd0, 5'd4, 2'd3, 2'd0, 5'd4, 5'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{5'd6, 5'd0, 2'd1, 2'd3, 5'd6, 5'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0};

    // Reset held with a hazard and an MDU issue present: outputs forced low.
    reset = 1'b0;
    set_idle();
    apply_vec(tbl[0]);
    bus.md_start_e = 1'b1; bus.md_use_d = 1'b1;
    repeat (2) @(negedge clk);
    check("reset stall",     32'(bus.stall),   32'd0);
    check("reset flush",     32'(bus.flush_e), 32'd0);
    check("reset busy",      32'(bus.md_busy), 32'd0);
    check("reset stall_cnt", bus.stall_cnt,    32'd0);
    set_idle();
    #1 reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      set_idle();
      apply_vec(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d stall", i), 32'(bus.stall),   32'(tbl[i].exp_stall));
      check($sformatf("vec%0d flush", i), 32'(bus.flush_e), 32'(tbl[i].exp_stall));
      $display("vec %0d: stall=%0b expected=%0b", i, bus.stall, tbl[i].exp_stall);
    end

    pulse_reset();
    mdu_seq(1'b0, MC, "mult");
    mdu_seq(1'b1, DC, "div");

    // Abort a busy window with reset when the counter is at 3.
    @(posedge clk); #1;
    set_idle();
    bus.md_start_e = 1'b1; bus.md_use_d = 1'b1;
    @(posedge clk); #1 bus.md_start_e = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre-abort busy", 32'(bus.md_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort busy",  32'(bus.md_busy), 32'd0);
    check("abort stall", 32'(bus.stall),   32'd0);
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 bus.md_use_d = 1'b1;
    @(negedge clk);
    check("post-abort stall", 32'(bus.stall),   32'd0);
    check("post-abort busy",  32'(bus.md_busy), 32'd0);
    $display("seq abort: reset mid-window checked");

    // Seven hazard cycles; the counter only exists in the STALL_CNT_EN build.
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      set_idle();
      apply_vec(tbl[0]);
      @(negedge clk);
    end
    @(posedge clk); #1 set_idle();
    @(negedge clk);
`ifdef STALL_CNT_EN
    check("stall_cnt after 7", bus.stall_cnt, 32'd7);
    force dut.r_stall_cnt = 32'hFFFF_FFFD;
    #1 release dut.r_stall_cnt;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 apply_vec(tbl[0]);
      @(negedge clk);
    end
    @(posedge clk); #1 set_idle();
    @(negedge clk);
    check("stall_cnt saturate", bus.stall_cnt, 32'hFFFF_FFFF);
`else
    check("stall_cnt tied 0", bus.stall_cnt, 32'd0);
`endif
    $display("seq stall_cnt: counter checked, value=%0h", bus.stall_cnt);

    // Randomized run: MDU modelled as "busy through cycle busy_until".
    pulse_reset();
    cyc        = 0;
    busy_until = -1;
    cnt_model  = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      bus.a1_d = 5'($urandom_range(0, 3));
      bus.a2_d = 5'($urandom_range(0, 3));
      bus.tuse_rs_d = 2'($urandom_range(0, 3));
      bus.tuse_rt_d = 2'($urandom_range(0, 3));
      bus.a3_e = 5'($urandom_range(0, 3));
      bus.a3_m = 5'($urandom_range(0, 3));
      bus.tnew_e = 2'($urandom_range(0, 3));
      bus.tnew_m = 2'($urandom_range(0, 3));
      bus.regwrite_e = 1'($urandom_range(0, 1));
      bus.regwrite_m = 1'($urandom_range(0, 1));
      bus.md_use_d   = 1'($urandom_range(0, 1));
      bus.md_start_e = ($urandom_range(0, 7) == 0);
      bus.md_div_e   = 1'($urandom_range(0, 1));

      hz = model_src_hit(int'(bus.a1_d), int'(bus.tuse_rs_d), int'(bus.a3_e), int'(bus.tnew_e),
                         bus.regwrite_e, int'(bus.a3_m), int'(bus.tnew_m), bus.regwrite_m) ||
           model_src_hit(int'(bus.a2_d), int'(bus.tuse_rt_d), int'(bus.a3_e), int'(bus.tnew_e),
                         bus.regwrite_e, int'(bus.a3_m), int'(bus.tnew_m), bus.regwrite_m);
      exp_busy  = bus.md_start_e || (cyc <= busy_until);
      exp_stall = hz || (bus.md_use_d && exp_busy);
`ifdef STALL_CNT_EN
      exp_cnt = 32'(cnt_model);
`else
      exp_cnt = 32'd0;
`endif
      @(negedge clk);
      check($sformatf("rand%0d stall", n), 32'(bus.stall),   32'(exp_stall));
      check($sformatf("rand%0d flush", n), 32'(bus.flush_e), 32'(exp_stall));
      check($sformatf("rand%0d busy", n),  32'(bus.md_busy), 32'(exp_busy));
      check($sformatf("rand%0d cnt", n),   bus.stall_cnt,    exp_cnt);

      if (bus.md_start_e) busy_until = cyc + (bus.md_div_e ? DC : MC);
      if (exp_stall && cnt_model < 64'hFFFF_FFFF) cnt_model++;
      cyc++;
    end
    $display("seq random: 400 cycles compared against model");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Hazard and multiply/divide scheduling controller for the five-stage MIPS pipeline. Compares the D-stage source registers against the E- and M-stage destination registers using the Tuse/Tnew scheme and freezes the front end when the producer cannot forward in time. Also owns the busy window of the multi-cycle HI/LO unit and stalls HI/LO consumers while it runs. Drives the PC/D-register enables and the E-register bubble clear.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issue (≥1)
- DIV_CYCLES, 10, busy cycles after a div/divu issue (≥1)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- a1_d, a2_d  in  5  D-stage rs/rt register numbers
- tuse_rs_d, tuse_rt_d  in  2  cycles until operand is needed; 3 = operand not read
- a3_e, a3_m  in  5  E/M destination register
- tnew_e, tnew_m  in  2  cycles until E/M result is forwardable
- regwrite_e, regwrite_m  in  1  E/M instruction writes GPR
- md_use_d  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- md_start_e  in  1  E-stage instruction is mult/div (issues to MDU this cycle)
- md_div_e  in  1  with md_start_e: 1 = divide, 0 = multiply
- stall  out  1  hold PC and D register (enable low)
- flush_e  out  1  clear E register at next edge (bubble)
- md_busy  out  1  MDU occupied
- stall_cnt  out  32  stall-cycle counter (only with STALL_CNT_EN)

## Operation
- Data hazard, per source s ∈ {rs, rt}: hit if a_d ≠ 0 and tuse_s ≠ 3 and any of
  - regwrite_e & a3_e == a_d & tnew_e > tuse_s
  - regwrite_m & a3_m == a_d & tnew_m > tuse_s
- Comparisons are unsigned 2-bit; register 0 never hazards.
- MDU FSM, states IDLE, BUSY; 4-bit-minimum down-counter cnt sized for max(MULT_CYCLES, DIV_CYCLES).
  - IDLE: md_start_e → BUSY, cnt ← md_div_e ? DIV_CYCLES : MULT_CYCLES.
  - BUSY: cnt ← cnt−1 each edge; when cnt == 1 at an edge → IDLE, cnt ← 0.
  - BUSY with md_start_e (not expected, since issue is stalled): reload cnt with the new op's count and stay BUSY.
- md_busy = md_start_e | (state == BUSY), combinational.
- MDU hazard = md_use_d & md_busy.
- stall = rs hit | rt hit | MDU hazard; flush_e = stall.

## Timing
- stall, flush_e and md_busy are combinational from the current inputs and state; zero latency.
- A mult issued in E at cycle t gives md_busy = 1 for cycles t … t+MULT_CYCLES (1+N cycles); same for div with DIV_CYCLES.
- Reset asserted, asynchronously: state IDLE, cnt 0, stall_cnt 0. While reset is low, stall, flush_e and md_busy are forced 0.
- Reset deassertion is synchronized by the system; the first edge after release is normal operation.
- Reset mid-BUSY aborts the window immediately.

## Configuration
- STALL_CNT_EN defined: stall_cnt increments on every rising edge with stall = 1 and saturates at 32'hFFFF_FFFF. Reset clears it.
- STALL_CNT_EN undefined: stall_cnt is tied to 0 and the counter is not instantiated.
- Hazard and MDU behaviour are identical in both builds.

## Structure
- Shared package pipe_pkg:
  - TUSE_NONE = 2'd3
  - MDU state enum {MDU_IDLE, MDU_BUSY}
  - default cycle constants MULT_CYCLES_DEF = 5 and DIV_CYCLES_DEF = 10
- One sub-module, mdu_sched: FSM plus counter, producing md_busy.
- Hazard comparison and stall counter stay in the top module.

## Test plan
- lw $1 in E (tnew_e=2, regwrite_e=1, a3_e=1), D addu reading rs=1 with tuse_rs=1 → stall=1, flush_e=1. Same with tuse_rs=2 → stall=0.
- a3_e = 0 with regwrite_e = 1, and a1_d = 0 with tuse_rs = 0 → stall = 0. D instruction with tuse_rt = 3 and matching a2_d → stall = 0.
- M-stage hazard: tnew_m = 1, a3_m = a2_d = 5, tuse_rt = 0 → stall = 1. Same with tnew_m = 0 → stall = 0.
- md_start_e = 1, md_div_e = 0 at cycle t, then md_use_d = 1 held → stall = 1 for cycles t … t+5, and 0 at t+6. Repeat with md_div_e = 1 → stall through t+10.
- Assert reset low during BUSY at cnt = 3 → md_busy = 0 immediately. After release, md_use_d = 1 gives stall = 0.
- With STALL_CNT_EN: 7 stall cycles → stall_cnt = 7. Preload near saturation by forcing → holds at FFFF_FFFF.
